// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative CORDIC vectoring engine returning magnitude and atan2 phase of a Q1.15 pair
module cordic_vectoring #(
  parameter int ITER = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic        [16:0] mag_out,
  output logic signed [17:0] phase_out
);
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE, S_DONE} state_t;
  localparam logic signed [17:0] PI = 18'sd102944;
  localparam logic signed [16:0] K = 17'sh04DBA;
  localparam logic [2:0] N_LAST = 3'(ITER - 1);
  state_t             state_q;
  logic        [2:0]  n_q;
  logic signed [17:0] x_q, y_q, z_q, x_d, y_d, z_d, xe, ye, atan;
  logic signed [34:0] prod;
  logic        [16:0] mag_q;
  logic signed [17:0] ph_q;
  logic               zero_q;
  function automatic logic signed [17:0] atan_lut(input logic [2:0] k);
    case (k)
      3'd0: return 18'sh06488;
      3'd1: return 18'sh03B59;
      3'd2: return 18'sh01F5B;
      3'd3: return 18'sh00FEB;
      3'd4: return 18'sh007FD;
      3'd5: return 18'sh00400;
      3'd6: return 18'sh00200;
      default: return 18'sh00100;
    endcase
  endfunction
  always_comb begin
    xe   = {{2{x_in[15]}}, x_in};
    ye   = {{2{y_in[15]}}, y_in};
    atan = atan_lut(n_q);
    x_d  = y_q[17] ? x_q - (y_q >>> n_q) : x_q + (y_q >>> n_q);
    y_d  = y_q[17] ? y_q + (x_q >>> n_q) : y_q - (x_q >>> n_q);
    z_d  = y_q[17] ? z_q - atan : z_q + atan;
    prod = 35'(x_q) * 35'(K);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mag_q   <= '0;
      ph_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          // left half-plane vectors are pre-rotated by pi so the iterations only cover +-pi/2
          x_q     <= x_in[15] ? -xe : xe;
          y_q     <= x_in[15] ? -ye : ye;
          z_q     <= x_in[15] ? (y_in[15] ? -PI : PI) : '0;
          n_q     <= '0;
          zero_q  <= (x_in == 16'sd0) && (y_in == 16'sd0);
          state_q <= S_ITER;
        end
        S_ITER: begin
          x_q     <= x_d;
          y_q     <= y_d;
          z_q     <= z_d;
          n_q     <= n_q + 3'd1;
          state_q <= (n_q == N_LAST) ? S_SCALE : S_ITER;
        end
        S_SCALE: begin
          mag_q   <= zero_q ? '0 : 17'(prod >>> 15);
          ph_q    <= zero_q ? '0 : z_q;
          state_q <= S_DONE;
        end
        S_DONE: if (out_ready) state_q <= S_IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign mag_out   = mag_q;
  assign phase_out = ph_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: randomized and directed checks of cordic_vectoring against a real-arithmetic atan2/hypot model
module tb_cordic_vectoring;
  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic               out_valid;
  logic               out_ready;
  logic        [16:0] mag_out;
  logic signed [17:0] phase_out;
  int n_checks = 0;
  int n_fail = 0;

  cordic_vectoring #(.ITER(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .mag_out(mag_out), .phase_out(phase_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic real fabs(input real r);
    return r < 0.0 ? -r : r;
  endfunction

  function automatic real model_mag(input int x, input int y);
    return $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
  endfunction

  function automatic real model_ph(input int x, input int y);
    return $atan2(real'(y), real'(x)) * 32768.0;
  endfunction

  task automatic run_pair(input int x, input int y, output int lat,
                          output logic [16:0] m, output logic signed [17:0] p);
    x_in = 16'(x);
    y_in = 16'(y);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    m = mag_out;
    p = phase_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x_in = '0;
    y_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (mag_out !== 17'd0) begin n_fail++; $display("FAIL reset mag: got %0d want 0", mag_out); end
    n_checks++;
    if (phase_out !== 18'sd0) begin n_fail++; $display("FAIL reset phase: got %0d want 0", phase_out); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int dx[5] = '{16384, 0, 16384, -16384, -32768};
    int dy[5] = '{0, 16384, -16384, 0, -32768};
    int lat;
    logic [16:0] m;
    logic signed [17:0] p;
    real em, ep;
    for (int i = 0; i < 5; i++) begin
      run_pair(dx[i], dy[i], lat, m, p);
      em = model_mag(dx[i], dy[i]);
      ep = model_ph(dx[i], dy[i]);
      n_checks++;
      if (lat !== 9) begin n_fail++; $display("FAIL directed%0d latency: got %0d want 9", i, lat); end
      n_checks++;
      if (fabs(real'(m) - em) > 0.005 * em + 2.0) begin
        n_fail++; $display("FAIL directed%0d mag: got %0d want %0.1f", i, m, em);
      end
      n_checks++;
      if (fabs(real'(p) - ep) > 300.0) begin
        n_fail++; $display("FAIL directed%0d phase: got %0d want %0.1f", i, p, ep);
      end
    end
    run_pair(-5000, 0, lat, m, p);
    n_checks++;
    if (p < 18'sd0 || fabs(real'(p) - 102944.0) > 300.0) begin
      n_fail++; $display("FAIL neg_x_zero_y phase: got %0d want ~102944", p);
    end
  endtask

  task automatic test_zero();
    int lat;
    logic [16:0] m;
    logic signed [17:0] p;
    run_pair(0, 0, lat, m, p);
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL zero latency: got %0d want 9", lat); end
    n_checks++;
    if (m !== 17'd0) begin n_fail++; $display("FAIL zero mag: got %0d want 0", m); end
    n_checks++;
    if (p !== 18'sd0) begin n_fail++; $display("FAIL zero phase: got %0d want 0", p); end
  endtask

  task automatic test_random();
    int x, y, lat;
    logic [16:0] m;
    logic signed [17:0] p;
    real em, ep;
    for (int i = 0; i < 24; i++) begin
      do begin
        x = int'($urandom_range(0, 65535)) - 32768;
        y = int'($urandom_range(0, 65535)) - 32768;
      end while (model_mag(x, y) < 2048.0);
      run_pair(x, y, lat, m, p);
      em = model_mag(x, y);
      ep = model_ph(x, y);
      n_checks++;
      if (lat !== 9) begin n_fail++; $display("FAIL random%0d latency: got %0d want 9", i, lat); end
      n_checks++;
      if (fabs(real'(m) - em) > 0.005 * em + 2.0) begin
        n_fail++; $display("FAIL random%0d mag (x=%0d y=%0d): got %0d want %0.1f", i, x, y, m, em);
      end
      n_checks++;
      if (fabs(real'(p) - ep) > 300.0) begin
        n_fail++; $display("FAIL random%0d phase (x=%0d y=%0d): got %0d want %0.1f", i, x, y, p, ep);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat = 0;
    real em = model_mag(12288, 4096);
    real ep = model_ph(12288, 4096);
    x_in = 16'sd12288;
    y_in = 16'sd4096;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    x_in = -16'sd20000;
    y_in = 16'sd7000;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL bp latency: got %0d want 9", lat); end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp hold%0d: got valid=%b ready=%b want 1/0", c, out_valid, in_ready);
      end
      n_checks++;
      if (fabs(real'(mag_out) - em) > 0.005 * em + 2.0 || fabs(real'(phase_out) - ep) > 300.0) begin
        n_fail++; $display("FAIL bp data%0d: got mag=%0d ph=%0d want %0.1f/%0.1f", c, mag_out, phase_out, em, ep);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL bp release%0d: got valid=%b ready=%b want 0/1", c, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [16:0] m;
    logic signed [17:0] p;
    real em = model_mag(-9000, 21000);
    real ep = model_ph(-9000, 21000);
    x_in = 16'sd30000;
    y_in = -16'sd1000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid ctrl: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (mag_out !== 17'd0 || phase_out !== 18'sd0) begin
      n_fail++; $display("FAIL rstmid data: got mag=%0d ph=%0d want 0/0", mag_out, phase_out);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid stale%0d: got valid=%b want 0", c, out_valid); end
    end
    run_pair(-9000, 21000, lat, m, p);
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL rstmid latency: got %0d want 9", lat); end
    n_checks++;
    if (fabs(real'(m) - em) > 0.005 * em + 2.0 || fabs(real'(p) - ep) > 300.0) begin
      n_fail++; $display("FAIL rstmid result: got mag=%0d ph=%0d want %0.1f/%0.1f", m, p, em, ep);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int nv = 0;
    real em = model_mag(8192, -8192);
    x_in = 16'sd8192;
    y_in = -16'sd8192;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (in_ready) acc.push_back(c);
      if (out_valid) begin
        nv++;
        n_checks++;
        if (fabs(real'(mag_out) - em) > 0.005 * em + 2.0) begin
          n_fail++; $display("FAIL b2b mag at %0d: got %0d want %0.1f", c, mag_out, em);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc.size() !== 5) begin n_fail++; $display("FAIL b2b accepts: got %0d want 5", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] !== 11) begin
        n_fail++; $display("FAIL b2b interval%0d: got %0d want 11", i, acc[i] - acc[i-1]);
      end
    end
    n_checks++;
    if (nv !== 4) begin n_fail++; $display("FAIL b2b transfers: got %0d want 4", nv); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative CORDIC vectoring-mode engine: accepts a Q1.15 Cartesian pair (x, y) and returns its magnitude and phase (atan2(y, x)) in radians. It is the inverse companion of the rotation-mode CORDIC iteration block in the transform datapath. It uses the same Q1.15 micro-rotation angle table and the same 0.607253 gain correction. It recovers polar form from rotated or transformed samples, e.g. bin magnitude/phase after the twiddle stage.

## Interface
- ITER, default 8: number of micro-rotations; legal range 1..8.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  input pair present.
- in_ready  out  1  block can accept a pair (high only in IDLE).
- x_in  in  16  signed Q1.15 x.
- y_in  in  16  signed Q1.15 y.
- out_valid  out  1  result present; held until accepted.
- out_ready  in  1  downstream accepts result.
- mag_out  out  17  unsigned magnitude, LSB = 2^-15 (range 0..~1.4142).
- phase_out  out  18  signed phase, Q3.15 radians, range [-π, +π]; π = 0x19220 (102944).

## Operation
- FSM states and transitions:
  - IDLE → ITER on in_valid && in_ready.
  - ITER → SCALE after ITER micro-rotations.
  - SCALE → DONE after 1 cycle.
  - DONE → IDLE on out_ready.
- Capture (IDLE, handshake):
  - Sign-extend x_in, y_in to 18-bit internal x, y; set counter n = 0.
  - If x_in < 0, pre-rotate by π: x = -x_in, y = -y_in, and z = +π if y_in >= 0, else -π.
  - Otherwise z = 0.
  - Also latch flag zero_in = (x_in == 0 && y_in == 0).
- ITER, one micro-rotation per cycle at shift n:
  - If y >= 0: x += y>>>n, y -= x>>>n, z += atan_lut[n].
  - Else: x -= y>>>n, y += x>>>n, z -= atan_lut[n].
  - All right-hand sides use the pre-update values. Shifts are arithmetic. n increments each cycle.
- atan_lut[0..7] (Q1.15, round(atan(2^-k)·2^15)): 0x6488, 0x3B59, 0x1F5B, 0x0FEB, 0x07FD, 0x0400, 0x0200, 0x0100.
- Widths:
  - x, y are 18-bit signed; no overflow is possible for any 16-bit input.
  - z is 18-bit signed. x stays >= 0 throughout ITER.
- SCALE:
  - mag_out <= (x · 17'sh04DBA) >>> 15, truncated to 17 bits. The product is a 35-bit signed intermediate.
  - phase_out <= z.
  - If zero_in: mag_out <= 0 and phase_out <= 0. Latency is unchanged.
- DONE: out_valid = 1. mag_out and phase_out are stable while out_ready = 0.
- Boundary conditions:
  - in_valid while busy: ignored, no capture.
  - x_in = -32768: negation to +32768 is exact in 18 bits.
  - y_in = 0 with x_in < 0: phase_out = +π.
  - out_ready held high in DONE: exactly one transfer, then IDLE.
  - out_ready high outside DONE: no effect.
- Reset (rst = 0 at a rising edge):
  - State → IDLE; n, x, y, z → 0; mag_out, phase_out → 0; out_valid → 0; in_ready → 1 on the following cycle.
  - An in-flight operation is discarded with no output. This applies in any state, including DONE with out_valid high.

## Timing
- Accept at edge E0. ITER edges E1..E_ITER perform the micro-rotations; edge E_(ITER+1) performs SCALE.
- out_valid is high after edge ITER+1 (9 cycles for ITER = 8).
- With out_ready tied high: DONE → IDLE at the next edge, and in_ready is high one cycle later.
- Sustained throughput is one pair per ITER+3 cycles (11 for ITER = 8).
- in_ready and out_valid are pure state decodes, registered-state based. There is no combinational path from in_valid or out_ready.
- Accuracy for ITER = 8: phase error ≤ 300 LSB; magnitude error ≤ 0.5% + 2 LSB.

## Test plan
- (0x4000, 0x0000) -> mag_out 16384 ±84, phase_out 0 ±300; out_valid high exactly 9 cycles after accept.
- (0x0000, 0x4000) -> phase_out +51472 (π/2) ±300. (0x4000, -0x4000) -> mag_out 23170 ±118, phase_out -25736 ±300.
- (-0x4000, 0x0000) -> phase_out +102944 (π) ±300. (-32768, -32768) -> mag_out 46341 ±234, phase_out -77208 (-3π/4) ±300.
- (0, 0) -> mag_out 0, phase_out 0, same 9-cycle latency.
- Back-pressure: hold out_ready low 5 cycles in DONE -> outputs stable, in_ready low. Assert in_valid with a new pair meanwhile -> it is not captured. Release out_ready -> one transfer, then IDLE.
- Reset mid-ITER (rst low at cycle 4 after accept) -> next cycle out_valid 0, mag_out/phase_out 0, in_ready 1. A fresh pair afterwards gives correct results and no stale output.
